// File: rtl/sa_psum_drain_if.sv
// Stream bundle for the PSUM drain: skewed bottom-row sums in, aligned rows out.
// master drives the array/writeback side, slave is the drain itself.
interface sa_psum_drain_if #(
    parameter int unsigned COLS  = 4,
    parameter int unsigned SUM_W = 24
);
    logic                  i_row_valid;
    logic [COLS*SUM_W-1:0] i_sum;
    logic                  o_valid;
    logic                  i_ready;
    logic [COLS*SUM_W-1:0] o_data;

    modport master (
        output i_row_valid,
        output i_sum,
        output i_ready,
        input  o_valid,
        input  o_data
    );

    modport slave (
        input  i_row_valid,
        input  i_sum,
        input  i_ready,
        output o_valid,
        output o_data
    );
endinterface

// File: rtl/sa_psum_drain.sv
// De-skews the staggered bottom-row partial sums into aligned rows and buffers them in a
// first-word-fall-through FIFO; rows completing into a full FIFO are dropped and counted.
module sa_psum_drain #(
    parameter int unsigned COLS  = 4,
    parameter int unsigned SUM_W = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_clear,
    sa_psum_drain_if.slave         bus,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow,
    output logic [7:0]             o_drop_cnt
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned RowW = COLS * SUM_W;

    logic [COLS-1:0]  w_vs;
    logic [COLS-1:1]  r_vs;
    logic [RowW-1:0]  w_tail_row;
    logic [RowW-1:0]  r_stage;
    logic             r_stage_vld;
    logic [RowW-1:0]  r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [LvlW-1:0]  r_level;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // vs[0] is the live input; vs[j] marks column j of the same row j cycles later.
    assign w_vs = {r_vs, bus.i_row_valid};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vs <= '0;
        end else if (i_clear) begin
            r_vs <= '0;
        end else begin
            r_vs <= w_vs[COLS-2:0];
        end
    end

    // Column j is captured when vs[j] is set, then delayed so every column lands in the
    // staging register on the edge that captures the last column.
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int unsigned Len = COLS - 1 - j;
        if (Len == 0) begin : g_last
            assign w_tail_row[j*SUM_W +: SUM_W] = bus.i_sum[j*SUM_W +: SUM_W];
        end else begin : g_dly
            logic [SUM_W-1:0] r_dl [Len];
            always_ff @(posedge clock) begin
                if (w_vs[j]) begin
                    r_dl[0] <= bus.i_sum[j*SUM_W +: SUM_W];
                end
                for (int unsigned k = 1; k < Len; k++) begin
                    r_dl[k] <= r_dl[k-1];
                end
            end
            assign w_tail_row[j*SUM_W +: SUM_W] = r_dl[Len-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stage_vld <= 1'b0;
        end else if (i_clear) begin
            r_stage_vld <= 1'b0;
        end else begin
            r_stage_vld <= w_vs[COLS-1];
        end
    end

    always_ff @(posedge clock) begin
        if (w_vs[COLS-1]) begin
            r_stage <= w_tail_row;
        end
    end

    // A full FIFO still accepts a row when the head leaves on the same edge.
    assign w_full = (r_level == LvlW'(DEPTH));
    assign w_pop  = bus.o_valid & bus.i_ready;
    assign w_push = r_stage_vld & (!w_full | w_pop);
    assign w_drop = r_stage_vld & w_full & !w_pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LvlW'(1);
                2'b01:   r_level <= r_level - LvlW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!i_clear && w_push) begin
            r_mem[r_wr_ptr] <= r_stage;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (i_clear) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Gate the head with valid so o_data reads zero while empty, including during reset.
    assign bus.o_valid = (r_level != '0);
    assign bus.o_data  = bus.o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_level     = r_level;
    assign o_overflow  = r_overflow;
    assign o_drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_sa_psum_drain.sv
// Directed bench for sa_psum_drain: latency, back-to-back streaming, overflow, mid-run
// reset and clear, with expected rows computed from the stimulus formula.
module tb_sa_psum_drain;
    localparam int COLS  = 4;
    localparam int SUM_W = 24;
    localparam int DEPTH = 4;
    localparam int RowW  = COLS * SUM_W;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   clear = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic                   ovf;
    logic [7:0]             drops;
    int                     n_cmp = 0;
    int                     n_err = 0;

    sa_psum_drain_if #(.COLS(COLS), .SUM_W(SUM_W)) bus ();

    sa_psum_drain #(.COLS(COLS), .SUM_W(SUM_W), .DEPTH(DEPTH)) dut (
        .clock      (clk),
        .reset      (rst_n),
        .i_clear    (clear),
        .bus        (bus),
        .o_level    (level),
        .o_overflow (ovf),
        .o_drop_cnt (drops)
    );

    always #5 clk = ~clk;

    function automatic logic [SUM_W-1:0] cval(input int base, input int k, input int j);
        return SUM_W'(base + k * 16 + j);
    endfunction

    function automatic logic [RowW-1:0] row_word(input int base, input int k);
        logic [RowW-1:0] w;
        w = '0;
        for (int j = 0; j < COLS; j++) w[j*SUM_W +: SUM_W] = cval(base, k, j);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive cycle t of a burst of nrows skewed rows (row k starts at cycle k), then clock it.
    task automatic drive_skew(input int t, input int base, input int nrows);
        bus.i_row_valid = (t < nrows);
        for (int j = 0; j < COLS; j++) begin
            if (t - j >= 0 && t - j < nrows) bus.i_sum[j*SUM_W +: SUM_W] = cval(base, t - j, j);
            else bus.i_sum[j*SUM_W +: SUM_W] = '0;
        end
        tick();
    endtask

    task automatic test_reset();
        bus.i_row_valid = 1'b0;
        bus.i_sum       = '0;
        bus.i_ready     = 1'b0;
        #2;
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_cmp++; if (drops !== 8'd0) begin n_err++; $display("FAIL reset_drops: got %0d want 0", drops); end
        n_cmp++; if (bus.o_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.o_data); end
        #5 rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_single();
        bus.i_ready     = 1'b1;
        bus.i_row_valid = 1'b1;
        bus.i_sum       = {72'h0, 24'h000001};
        tick();
        bus.i_row_valid = 1'b0;
        bus.i_sum       = {48'h0, 24'hFFFFFF, 24'h0};
        tick();
        bus.i_sum = {24'h0, 24'h800000, 48'h0};
        tick();
        bus.i_sum = {24'h7FFFFF, 72'h0};
        tick();
        bus.i_sum = '0;
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got %b want 0", bus.o_valid); end
        tick();
        n_cmp++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", bus.o_valid); end
        n_cmp++; if (bus.o_data !== 96'h7FFFFF_800000_FFFFFF_000001) begin n_err++; $display("FAIL single_data: got %h want 7fffff800000ffffff000001", bus.o_data); end
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", level); end
        tick();
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL single_popped: got %b want 0", bus.o_valid); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL single_level_end: got %0d want 0", level); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        bus.i_ready = 1'b1;
        for (int t = 0; t <= 12; t++) begin
            drive_skew(t, 0, 8);
            exp_v = (t >= 4 && t <= 11);
            n_cmp++; if (bus.o_valid !== exp_v) begin n_err++; $display("FAIL b2b_valid t=%0d: got %b want %b", t, bus.o_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (bus.o_data !== row_word(0, t - 4)) begin n_err++; $display("FAIL b2b_data t=%0d: got %h want %h", t, bus.o_data, row_word(0, t - 4)); end
            end
        end
        n_cmp++; if (drops !== 8'd0) begin n_err++; $display("FAIL b2b_drops: got %0d want 0", drops); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_overflow();
        bus.i_ready = 1'b0;
        for (int t = 0; t <= 8; t++) begin
            drive_skew(t, 'h1000, 5);
            if (t == 7) begin
                n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL ovf_full_level: got %0d want 4", level); end
                n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", ovf); end
            end
        end
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL ovf_level: got %0d want 4", level); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        n_cmp++; if (drops !== 8'd1) begin n_err++; $display("FAIL ovf_drops: got %0d want 1", drops); end
        n_cmp++; if (bus.o_data !== row_word('h1000, 0)) begin n_err++; $display("FAIL ovf_hold: got %h want %h", bus.o_data, row_word('h1000, 0)); end
        bus.i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL ovf_drain_valid k=%0d: got %b want 1", k, bus.o_valid); end
            n_cmp++; if (bus.o_data !== row_word('h1000, k)) begin n_err++; $display("FAIL ovf_drain_data k=%0d: got %h want %h", k, bus.o_data, row_word('h1000, k)); end
            tick();
        end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL ovf_drain_level: got %0d want 0", level); end
    endtask

    task automatic test_push_pop_full();
        for (int t = 0; t <= 8; t++) begin
            bus.i_ready = (t == 8);
            drive_skew(t, 'h2000, 5);
        end
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL pp_level: got %0d want 4", level); end
        n_cmp++; if (drops !== 8'd1) begin n_err++; $display("FAIL pp_drops: got %0d want 1", drops); end
        for (int k = 1; k <= 4; k++) begin
            n_cmp++; if (bus.o_data !== row_word('h2000, k)) begin n_err++; $display("FAIL pp_data k=%0d: got %h want %h", k, bus.o_data, row_word('h2000, k)); end
            tick();
        end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL pp_empty: got %b want 0", bus.o_valid); end
    endtask

    task automatic test_reset_mid();
        bus.i_ready = 1'b0;
        for (int t = 0; t <= 5; t++) drive_skew(t, 'h3000, 5);
        n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL rst_pre_level: got %0d want 2", level); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.o_valid); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        n_cmp++; if (drops !== 8'd0) begin n_err++; $display("FAIL rst_drops: got %0d want 0", drops); end
        n_cmp++; if (bus.o_data !== '0) begin n_err++; $display("FAIL rst_data: got %h want 0", bus.o_data); end
        bus.i_sum = '0;
        #2 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL rst_stale c=%0d: got %b want 0", c, bus.o_valid); end
        end
    endtask

    task automatic test_clear();
        bus.i_ready = 1'b0;
        for (int t = 0; t <= 307; t++) begin
            drive_skew(t, 'h4000, 304);
            if (t == 10) begin
                n_cmp++; if (drops !== 8'd3) begin n_err++; $display("FAIL clr_count: got %0d want 3", drops); end
            end
        end
        n_cmp++; if (drops !== 8'd255) begin n_err++; $display("FAIL clr_sat: got %0d want 255", drops); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL clr_ovf_set: got %b want 1", ovf); end
        // A row arriving on the clear edge must be discarded too.
        clear           = 1'b1;
        bus.i_row_valid = 1'b1;
        tick();
        clear           = 1'b0;
        bus.i_row_valid = 1'b0;
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL clr_level: got %0d want 0", level); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %b want 0", ovf); end
        n_cmp++; if (drops !== 8'd0) begin n_err++; $display("FAIL clr_drops: got %0d want 0", drops); end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL clr_stale c=%0d: got %b want 0", c, bus.o_valid); end
        end
        bus.i_ready = 1'b1;
        for (int t = 0; t <= 4; t++) begin
            drive_skew(t, 'h5000, 1);
            if (t == 3) begin
                n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL clr_lat_early: got %b want 0", bus.o_valid); end
            end
        end
        n_cmp++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL clr_lat_valid: got %b want 1", bus.o_valid); end
        n_cmp++; if (bus.o_data !== row_word('h5000, 0)) begin n_err++; $display("FAIL clr_lat_data: got %h want %h", bus.o_data, row_word('h5000, 0)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_reset_mid();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
